// File: rtl/rotate_pkg.sv
// rtl/rotate_pkg.sv - shared widths, direction codes and request record for the rotate arbiter
package rotate_pkg;

    localparam int DATA_W = 8;
    localparam int AMT_W  = 3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  amt;
        logic              dir;
    } rot_req_t;

endpackage

// File: rtl/rotate8_lr.sv
// rtl/rotate8_lr.sv - combinational 8-bit left/right rotator built from 1/2/4 log stages
module rotate8_lr
    import rotate_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [AMT_W-1:0]  amt,
    input  logic              dir,
    output logic [DATA_W-1:0] y
);

    logic [DATA_W-1:0] left_1, left_2, left_4;
    logic [DATA_W-1:0] right_1, right_2, right_4;

    assign left_1  = amt[0] ? {a[6:0], a[7]}             : a;
    assign left_2  = amt[1] ? {left_1[5:0], left_1[7:6]} : left_1;
    assign left_4  = amt[2] ? {left_2[3:0], left_2[7:4]} : left_2;

    assign right_1 = amt[0] ? {a[0], a[7:1]}               : a;
    assign right_2 = amt[1] ? {right_1[1:0], right_1[7:2]} : right_1;
    assign right_4 = amt[2] ? {right_2[3:0], right_2[7:4]} : right_2;

    assign y = (dir == DIR_RIGHT) ? right_4 : left_4;

endmodule

// File: rtl/rotate_arbiter.sv
// rtl/rotate_arbiter.sv - two-requester round-robin front end for the shared rotator with a one-entry response slot
module rotate_arbiter
    import rotate_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [AMT_W-1:0]  req0_amt,
    input  logic              req0_dir,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [AMT_W-1:0]  req1_amt,
    input  logic              req1_dir,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
);

    rot_req_t          req0, req1, sel_req;
    logic [1:0]        grant;
    logic              can_accept;
    logic              gnt_id;
    logic              prio;
    logic [DATA_W-1:0] rot_y;

    assign req0 = {req0_data, req0_amt, req0_dir};
    assign req1 = {req1_data, req1_amt, req1_dir};

    // The slot may take a new entry when it is empty or being drained this cycle.
    always_comb begin
        grant      = 2'b00;
        can_accept = !rsp_valid || rsp_ready;
        if (reset_n && can_accept) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign gnt_id    = grant[1];
    assign sel_req   = gnt_id ? req1 : req0;

    rotate8_lr u_rot (
        .a   (sel_req.data),
        .amt (sel_req.amt),
        .dir (sel_req.dir),
        .y   (rot_y)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            prio      <= 1'b0;
        end else if (|grant) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rot_y;
            rsp_id    <= gnt_id;
            prio      <= ~gnt_id;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Debug counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (grant[0] && (gnt_cnt0 != '1)) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
            if (grant[1] && (gnt_cnt1 != '1)) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rotate_arbiter.sv
// tb/tb_rotate_arbiter.sv - directed and randomized checks of rotate_arbiter against a behavioural model
module tb_rotate_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic [2:0] req0_amt = 3'd0, req1_amt = 3'd0;
    logic       req0_dir = 1'b0, req1_dir = 1'b0;
    logic       rsp_ready = 1'b0;

    logic [1:0] req_ready, req_ready2;
    logic       rsp_valid, rsp_valid2, rsp_id, rsp_id2;
    logic [7:0] rsp_data, rsp_data2, gnt_cnt0, gnt_cnt1;
    logic [1:0] gnt2_cnt0, gnt2_cnt1;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    rotate_arbiter #(.CNT_W(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req0_data(req0_data), .req0_amt(req0_amt), .req0_dir(req0_dir),
        .req1_data(req1_data), .req1_amt(req1_amt), .req1_dir(req1_dir),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    rotate_arbiter #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready2),
        .req0_data(req0_data), .req0_amt(req0_amt), .req0_dir(req0_dir),
        .req1_data(req1_data), .req1_amt(req1_amt), .req1_dir(req1_dir),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_data(rsp_data2), .rsp_id(rsp_id2),
        .gnt_cnt0(gnt2_cnt0), .gnt_cnt1(gnt2_cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rot_ref(input logic [7:0] a, input int k, input logic right);
        logic [15:0] x;
        logic [15:0] s;
        x = {a, a};
        if (right) begin
            s = x >> k;
            return s[7:0];
        end
        s = x << k;
        return s[15:8];
    endfunction

    // Behavioural model: one slot, a tie-break owner and two grant tallies.
    bit       m_known = 1'b0;
    bit       m_valid;
    bit [7:0] m_data;
    bit       m_id;
    int       m_winner;
    int       m_tally[2];

    always @(negedge clk) begin
        int g;
        bit can;
        logic [1:0] exp_rdy;
        g = -1;
        if (m_known) begin
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("rsp_data", 32'(rsp_data), 32'(m_data));
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("gnt_cnt0", 32'(gnt_cnt0), 32'((m_tally[0] > 255) ? 255 : m_tally[0]));
            chk("gnt_cnt1", 32'(gnt_cnt1), 32'((m_tally[1] > 255) ? 255 : m_tally[1]));
            chk("rsp_valid_w2", 32'(rsp_valid2), 32'(m_valid));
            chk("rsp_data_w2", 32'(rsp_data2), 32'(m_data));
            chk("gnt_cnt0_w2", 32'(gnt2_cnt0), 32'((m_tally[0] > 3) ? 3 : m_tally[0]));
            chk("gnt_cnt1_w2", 32'(gnt2_cnt1), 32'((m_tally[1] > 3) ? 3 : m_tally[1]));
        end
        if (reset_n && m_known) begin
            can = !m_valid || rsp_ready;
            if (can && req_valid == 2'b11) g = m_winner;
            else if (can && req_valid == 2'b01) g = 0;
            else if (can && req_valid == 2'b10) g = 1;
        end
        exp_rdy = (g < 0) ? 2'b00 : 2'(1 << g);
        if (!reset_n || m_known) begin
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("req_ready_w2", 32'(req_ready2), 32'(exp_rdy));
        end
        if (!reset_n) begin
            m_known = 1'b1;
            m_valid = 1'b0;
            m_data = 8'h00;
            m_id = 1'b0;
            m_winner = 0;
            m_tally[0] = 0;
            m_tally[1] = 0;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_data = (g == 0) ? rot_ref(req0_data, int'(req0_amt), req0_dir)
                              : rot_ref(req1_data, int'(req1_amt), req1_dir);
            m_id = (g == 1);
            m_winner = 1 - g;
            m_tally[g] = m_tally[g] + 1;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_valid = 2'b00;
        step();
        reset_n = 1'b1;
    endtask

    logic [1:0] acc;

    initial begin
        // Reset with both requesters asserting.
        reset_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        repeat (3) step();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_data", 32'(rsp_data), 32'h00);
        chk("rst_cnt0", 32'(gnt_cnt0), 32'h0);
        chk("rst_cnt1", 32'(gnt_cnt1), 32'h0);
        reset_n = 1'b1;
        #1 chk("first_tie", 32'(req_ready), 32'h1);
        step();
        chk("first_tie_id", 32'(rsp_id), 32'h0);

        // Single requests.
        req_valid = 2'b01; req0_data = 8'h81; req0_amt = 3'd1; req0_dir = 1'b0;
        step();
        chk("r0_81_l1", 32'(rsp_data), 32'h03);
        chk("r0_id", 32'(rsp_id), 32'h0);
        req_valid = 2'b10; req1_data = 8'h81; req1_amt = 3'd1; req1_dir = 1'b1;
        step();
        chk("r1_81_r1", 32'(rsp_data), 32'hC0);
        chk("r1_id", 32'(rsp_id), 32'h1);
        req_valid = 2'b00;
        step();

        // Continuous contention: strict alternation.
        do_reset();
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            #1 chk("alt_ready", 32'(req_ready), (k % 2) ? 32'h2 : 32'h1);
            step();
            chk("alt_id", 32'(rsp_id), 32'(k % 2));
            chk("alt_valid", 32'(rsp_valid), 32'h1);
        end
        req_valid = 2'b00;
        chk("alt_cnt0", 32'(gnt_cnt0), 32'h3);
        chk("alt_cnt1", 32'(gnt_cnt1), 32'h3);

        // Backpressure then same-cycle reload.
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        req0_data = 8'hA5; req0_amt = 3'd4; req0_dir = 1'b0;
        req1_data = 8'h3C; req1_amt = 3'd0; req1_dir = 1'b1;
        #1 chk("bp_first", 32'(req_ready), 32'h1);
        step();
        chk("a5_l4", 32'(rsp_data), 32'h5A);
        for (int k = 0; k < 4; k++) begin
            #1 chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_data", 32'(rsp_data), 32'h5A);
            step();
        end
        rsp_ready = 1'b1;
        #1 chk("bp_release", 32'(req_ready), 32'h2);
        step();
        chk("bp_reload_valid", 32'(rsp_valid), 32'h1);
        chk("bp_reload_id", 32'(rsp_id), 32'h1);
        chk("3c_r0", 32'(rsp_data), 32'h3C);

        // Reset while the slot is full.
        rsp_ready = 1'b0;
        req_valid = 2'b00;
        reset_n = 1'b0;
        step();
        chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_cnt1", 32'(gnt_cnt1), 32'h0);
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        step();
        chk("mid_rst_no_rsp", 32'(rsp_valid), 32'h0);
        req_valid = 2'b11;
        #1 chk("mid_rst_prio", 32'(req_ready), 32'h1);
        step();

        // Counter saturation on the narrow instance.
        do_reset();
        req_valid = 2'b01;
        repeat (5) step();
        req_valid = 2'b00;
        chk("sat_w2", 32'(gnt2_cnt0), 32'h3);
        chk("sat_w8", 32'(gnt_cnt0), 32'h5);
        step();
        chk("sat_hold", 32'(gnt2_cnt0), 32'h3);

        // Randomized traffic: requesters hold until accepted or voluntarily drop.
        acc = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 199) != 0);
            if (req_valid[0] && !acc[0]) begin
                if ($urandom_range(0, 9) == 0) req_valid[0] = 1'b0;
            end else begin
                req_valid[0] = 1'($urandom_range(0, 1));
                req0_data = 8'($urandom);
                req0_amt = 3'($urandom);
                req0_dir = 1'($urandom);
            end
            if (req_valid[1] && !acc[1]) begin
                if ($urandom_range(0, 9) == 0) req_valid[1] = 1'b0;
            end else begin
                req_valid[1] = 1'($urandom_range(0, 1));
                req1_data = 8'($urandom);
                req1_amt = 3'($urandom);
                req1_dir = 1'($urandom);
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            #1;
            acc = req_valid & req_ready;
            step();
        end

        req_valid = 2'b00;
        reset_n = 1'b1;
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
